// File: rtl/am2940_pkg.sv
// Shared definitions for the AM2940 microsequencer: instruction codes,
// control-register mode encodings and the sequencer state type.
package am2940_pkg;

    localparam logic [2:0] I_WRCR   = 3'b000;
    localparam logic [2:0] I_RDCR   = 3'b001;
    localparam logic [2:0] I_RDWC   = 3'b010;
    localparam logic [2:0] I_RDAC   = 3'b011;
    localparam logic [2:0] I_REINIT = 3'b100;
    localparam logic [2:0] I_LDAD   = 3'b101;
    localparam logic [2:0] I_LDWC   = 3'b110;
    localparam logic [2:0] I_ENCT   = 3'b111;

    localparam logic [1:0] MODE_WC_DEC    = 2'b00;
    localparam logic [1:0] MODE_WC_CMP    = 2'b01;
    localparam logic [1:0] MODE_ADDR_ONLY = 2'b10;
    localparam logic [1:0] MODE_WC_INC    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRCR  = 3'd1,
        ST_LDAD  = 3'd2,
        ST_LDWC  = 3'd3,
        ST_XFER  = 3'd4,
        ST_CHECK = 3'd5,
        ST_RDBK  = 3'd6,
        ST_FIN   = 3'd7
    } state_t;

    // Address-only mode never raises a meaningful DONE.
    function automatic logic mode_uses_done(input logic [1:0] mode);
        return mode != MODE_ADDR_ONLY;
    endfunction

endpackage

// File: rtl/am2940_sequencer.sv
// Microsequencer that programs an AM2940, issues one ENCT per accepted
// memory transfer and reads back the final address.
module am2940_sequencer
    import am2940_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [2:0]   cfg_cr,
    input  logic [W-1:0] cfg_addr,
    input  logic [W-1:0] cfg_count,
    input  logic         am_done,
    input  logic [W-1:0] am_data_in,
    output logic [2:0]   am_i,
    output logic [W-1:0] am_data_out,
    output logic         am_data_oe,
    output logic         xfer_req,
    input  logic         xfer_ack,
    output logic         busy,
    output logic         complete,
    output logic         err,
    output logic [W-1:0] final_addr,
    output logic [2:0]   dbg_state
);

    localparam logic [W-1:0] ONE = W'(1);

    state_t       state_q, state_d;
    logic [2:0]   cr_q, cr_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] rem_q, rem_d;
    logic         err_q, err_d;
    logic         tail_q, tail_d;
    logic         tail_abort_q, tail_abort_d;
    logic [2:0]   am_i_q, am_i_d;
    logic [W-1:0] data_q, data_d;
    logic         oe_q, oe_d;
    logic         req_q, req_d;
    logic         busy_q, busy_d;
    logic         complete_q, complete_d;
    logic [W-1:0] final_q, final_d;
    logic         enct_d;
    logic         early_done;

    // A "tail" XFER cycle carries the ENCT for the last accepted ack with
    // xfer_req already low; it then leaves for CHECK or, if aborting, RDBK.
    always_comb begin
        state_d      = state_q;
        cr_d         = cr_q;
        addr_d       = addr_q;
        count_d      = count_q;
        rem_d        = rem_q;
        err_d        = err_q;
        final_d      = final_q;
        tail_d       = 1'b0;
        tail_abort_d = 1'b0;
        enct_d       = 1'b0;
        early_done   = mode_uses_done(cr_q[1:0]) && am_done;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cr_d    = cfg_cr;
                    addr_d  = cfg_addr;
                    count_d = cfg_count;
                    rem_d   = cfg_count;
                    err_d   = 1'b0;
                    state_d = ST_WRCR;
                end
            end
            ST_WRCR: state_d = abort ? ST_RDBK : ST_LDAD;
            ST_LDAD: state_d = abort ? ST_RDBK : ST_LDWC;
            ST_LDWC: begin
                if (abort || rem_q == '0) begin
                    state_d = ST_RDBK;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tail_q) begin
                    state_d = (tail_abort_q || abort) ? ST_RDBK : ST_CHECK;
                end else begin
                    if (early_done) begin
                        err_d = 1'b1;
                    end
                    if (xfer_ack) begin
                        rem_d  = rem_q - ONE;
                        enct_d = 1'b1;
                        if (rem_q == ONE || abort || early_done) begin
                            tail_d       = 1'b1;
                            tail_abort_d = abort;
                        end
                    end else if (abort) begin
                        state_d = ST_RDBK;
                    end else if (early_done) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (!abort && mode_uses_done(cr_q[1:0]) && !am_done) begin
                    err_d = 1'b1;
                end
                state_d = ST_RDBK;
            end
            ST_RDBK: begin
                final_d = am_data_in;
                state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered.
    always_comb begin
        am_i_d     = enct_d ? I_ENCT : I_RDAC;
        data_d     = '0;
        oe_d       = 1'b0;
        req_d      = 1'b0;
        busy_d     = state_d != ST_IDLE;
        complete_d = state_d == ST_FIN;
        case (state_d)
            ST_WRCR: begin
                am_i_d = I_WRCR;
                data_d = {{(W-3){1'b0}}, cr_d};
                oe_d   = 1'b1;
            end
            ST_LDAD: begin
                am_i_d = I_LDAD;
                data_d = addr_d;
                oe_d   = 1'b1;
            end
            ST_LDWC: begin
                am_i_d = I_LDWC;
                data_d = count_d;
                oe_d   = 1'b1;
            end
            ST_XFER: req_d = !tail_d;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cr_q         <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            rem_q        <= '0;
            err_q        <= 1'b0;
            tail_q       <= 1'b0;
            tail_abort_q <= 1'b0;
            am_i_q       <= I_RDAC;
            data_q       <= '0;
            oe_q         <= 1'b0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            complete_q   <= 1'b0;
            final_q      <= '0;
        end else begin
            state_q      <= state_d;
            cr_q         <= cr_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
            tail_q       <= tail_d;
            tail_abort_q <= tail_abort_d;
            am_i_q       <= am_i_d;
            data_q       <= data_d;
            oe_q         <= oe_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            complete_q   <= complete_d;
            final_q      <= final_d;
        end
    end

    assign am_i        = am_i_q;
    assign am_data_out = data_q;
    assign am_data_oe  = oe_q;
    assign xfer_req    = req_q;
    assign busy        = busy_q;
    assign complete    = complete_q;
    assign err         = err_q;
    assign final_addr  = final_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_am2940_sequencer.sv
// Bench for am2940_sequencer: a behavioural AM2940 and memory responder,
// transaction-level expectations queued per block transfer.
module tb_am2940_sequencer;
    import am2940_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, abort;
    logic [2:0]   cfg_cr;
    logic [W-1:0] cfg_addr, cfg_count;
    logic         am_done;
    logic [W-1:0] am_data_in;
    logic [2:0]   am_i;
    logic [W-1:0] am_data_out;
    logic         am_data_oe, xfer_req, xfer_ack;
    logic         busy, complete, err;
    logic [W-1:0] final_addr;
    logic [2:0]   dbg_state;

    am2940_sequencer #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_cr(cfg_cr), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
        .am_done(am_done), .am_data_in(am_data_in),
        .am_i(am_i), .am_data_out(am_data_out), .am_data_oe(am_data_oe),
        .xfer_req(xfer_req), .xfer_ack(xfer_ack),
        .busy(busy), .complete(complete), .err(err),
        .final_addr(final_addr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Behavioural AM2940 state, updated from the instruction of each cycle.
    logic [W-1:0] env_addr = '0;
    logic         env_dir  = 1'b0;
    int           env_enct = 0;
    int           env_done_after = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic env_step(input logic [2:0] i, input logic oe, input logic [W-1:0] d);
        if (oe && i == I_WRCR) begin
            env_dir  = d[2];
            env_enct = 0;
        end else if (oe && i == I_LDAD) begin
            env_addr = d;
        end else if (i == I_ENCT) begin
            env_enct++;
            env_addr = env_dir ? env_addr - 1'b1 : env_addr + 1'b1;
        end
        am_done    = (env_done_after >= 0) && (env_enct >= env_done_after);
        am_data_in = env_addr;
    endtask

    // done_mode: 0 = DONE after count ENCTs, 1 = never, 2 = after j ENCTs.
    // abort_k > 0: abort together with the k-th ack. ack_mode: 0 random,
    // 1 every request cycle, 2 on odd request cycles only.
    task automatic run_txn(input logic [2:0] cr, input logic [W-1:0] addr, input int n,
                           input int done_mode, input int j, input int abort_k,
                           input int ack_mode);
        int e, acks, req_idx, cyc;
        logic err_e, cares, a, s_oe;
        logic [2:0] s_i;
        logic [W-1:0] s_d, fin;
        cares = cr[1:0] != MODE_ADDR_ONLY;
        if (n == 0) begin
            e = 0; err_e = 1'b0;
        end else if (abort_k > 0) begin
            e = abort_k; err_e = 1'b0;
        end else if (done_mode == 2 && cares) begin
            e = j; err_e = 1'b1;
        end else begin
            e = n; err_e = cares && (done_mode == 1);
        end
        fin = cr[2] ? addr - W'(e) : addr + W'(e);
        exp_q.push_back(W'(cr));
        exp_q.push_back(addr);
        exp_q.push_back(W'(n));
        exp_q.push_back(W'(e));
        exp_q.push_back(W'(err_e));
        exp_q.push_back(fin);

        env_done_after = (done_mode == 0) ? n : (done_mode == 1) ? -1 : j;
        env_enct = 0;
        am_done = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((busy || complete) && cyc < 100);
        if (cyc >= 100) begin
            $display("FAIL idle_timeout: busy still %0b, expected 0", busy);
            $fatal(1);
        end
        cfg_cr = cr; cfg_addr = addr; cfg_count = W'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        acks = 0; req_idx = 0;
        for (cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (complete) break;
            s_i = am_i; s_oe = am_data_oe; s_d = am_data_out;
            if (xfer_req) begin
                req_idx++;
                case (ack_mode)
                    1:       a = 1'b1;
                    2:       a = (req_idx % 2) == 1;
                    default: a = $urandom_range(0, 3) != 0;
                endcase
                if (done_mode == 2 && cares && acks >= j) a = 1'b0;
                xfer_ack = a;
                if (a) begin
                    acks++;
                    if (acks == abort_k) abort = 1'b1;
                end
            end
            @(posedge clk); #1;
            xfer_ack = 1'b0;
            abort = 1'b0;
            env_step(s_i, s_oe, s_d);
        end
        if (cyc >= 400) begin
            $display("FAIL complete_timeout: complete=%0b, expected 1", complete);
            $fatal(1);
        end
    endtask

    // Monitor: gathers what the DUT did during one busy period and checks it
    // against the oldest queued expectation when complete pulses.
    initial begin : monitor
        logic busy_prev;
        int m_enct, nw, busy_cyc;
        logic m_req, bad_oe;
        logic [2:0] w_i[3];
        logic [W-1:0] w_d[3];
        logic [W-1:0] e_cr, e_addr, e_n, e_e, e_err, e_fin;
        busy_prev = 1'b0;
        m_enct = 0; nw = 0; busy_cyc = 0; m_req = 1'b0; bad_oe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w_i[k] = '0; w_d[k] = '0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
            end else begin
                if (busy && !busy_prev) begin
                    m_enct = 0; nw = 0; busy_cyc = 0; m_req = 1'b0; bad_oe = 1'b0;
                end
                if (busy) begin
                    busy_cyc++;
                    if (am_i == I_ENCT) m_enct++;
                    if (xfer_req) m_req = 1'b1;
                    if (am_data_oe) begin
                        if (nw < 3) begin
                            w_i[nw] = am_i; w_d[nw] = am_data_out;
                        end
                        nw++;
                        if (!(am_i inside {I_WRCR, I_LDAD, I_LDWC})) bad_oe = 1'b1;
                    end
                end
                if (complete) begin
                    if (exp_q.size() < 6) begin
                        checks++; errors++;
                        $display("FAIL unexpected_complete: complete=1, expected no pulse");
                    end else begin
                        e_cr = exp_q.pop_front(); e_addr = exp_q.pop_front();
                        e_n = exp_q.pop_front(); e_e = exp_q.pop_front();
                        e_err = exp_q.pop_front(); e_fin = exp_q.pop_front();
                        check("setup_writes", nw, 3);
                        check("wrcr_word", {w_i[0], w_d[0]}, {I_WRCR, e_cr});
                        check("ldad_word", {w_i[1], w_d[1]}, {I_LDAD, e_addr});
                        check("ldwc_word", {w_i[2], w_d[2]}, {I_LDWC, e_n});
                        check("enct_count", m_enct, e_e);
                        check("err", err, e_err);
                        check("final_addr", final_addr, e_fin);
                        check("xfer_req_seen", m_req, e_n != 0);
                        check("oe_on_write_only", bad_oe, 0);
                        // Zero-count block: WRCR, LDAD, LDWC, RDBK, FIN.
                        if (e_n == 0) check("count0_busy_cycles", busy_cyc, 5);
                    end
                end
                busy_prev = busy;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin : main
        int n, dm, j, ak, cyc;
        logic seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; xfer_ack = 1'b0;
        cfg_cr = '0; cfg_addr = '0; cfg_count = '0;
        am_done = 1'b0; am_data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_am_i", am_i, I_RDAC);
        check("rst_oe", am_data_oe, 0);
        check("rst_data_out", am_data_out, 0);
        check("rst_xfer_req", xfer_req, 0);
        check("rst_busy", busy, 0);
        check("rst_complete", complete, 0);
        check("rst_err", err, 0);
        check("rst_final_addr", final_addr, 0);
        rst = 1'b0;

        run_txn(3'b000, 8'h40, 3, 0, 0, -1, 1);
        run_txn(3'b000, 8'h10, 0, 0, 0, -1, 1);
        run_txn(3'b010, 8'h20, 2, 1, 0, -1, 1);
        run_txn(3'b000, 8'h20, 2, 1, 0, -1, 1);
        run_txn(3'b000, 8'h80, 4, 0, 0, 2, 2);
        run_txn(3'b000, 8'h30, 4, 2, 1, -1, 1);
        run_txn(3'b100, 8'h01, 3, 0, 0, -1, 1);
        run_txn(3'b011, 8'hFE, 4, 0, 0, -1, 0);

        for (int t = 0; t < 24; t++) begin
            n  = $urandom_range(0, 6);
            dm = $urandom_range(0, 2);
            if (dm == 2 && n < 2) dm = 0;
            j  = (dm == 2) ? $urandom_range(1, n - 1) : 0;
            ak = -1;
            if (n > 0 && dm != 2 && $urandom_range(0, 3) == 0) ak = $urandom_range(1, n);
            run_txn(3'($urandom_range(0, 7)), W'($urandom), n, dm, j, ak, 0);
        end

        // Reset in the middle of a transfer: no complete pulse may follow.
        repeat (3) @(negedge clk);
        cfg_cr = 3'b000; cfg_addr = 8'h55; cfg_count = 8'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!xfer_req && cyc < 20);
        check("xfer_req_before_reset", xfer_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_am_i", am_i, I_RDAC);
        check("midrst_oe", am_data_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_xfer_req", xfer_req, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        seen = complete;
        repeat (10) begin
            @(negedge clk);
            seen = seen | complete;
        end
        check("midrst_no_complete", seen, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
